// File: rtl/johnson_checker_pkg.sv
// Shared encodings for the Johnson counter checker: lock FSM states and step classes.
package johnson_checker_pkg;

    localparam logic STATE_SEARCH = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    typedef enum logic [1:0] {
        StepHold = 2'd0,
        StepFwd  = 2'd1,
        StepBwd  = 2'd2,
        StepJump = 2'd3
    } step_e;

endpackage

// File: rtl/johnson_checker_decode.sv
// Combinational Johnson code decoder: flags legal codes and maps them to a sequence index.
module johnson_checker_decode #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] jc_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] index_o
);

    int unsigned ones;
    int unsigned bounds;

    always_comb begin
        ones   = 0;
        bounds = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (jc_i[i]) begin
                ones = ones + 1;
            end
        end
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (jc_i[i] != jc_i[i+1]) begin
                bounds = bounds + 1;
            end
        end
        legal_o = (bounds <= 1);
        // MSB set implies at least one 1, so 2*WIDTH - ones never reaches 2*WIDTH.
        if (jc_i[WIDTH-1]) begin
            index_o = IDX_W'(2 * WIDTH - ones);
        end else begin
            index_o = IDX_W'(ones);
        end
    end

endmodule

// File: rtl/johnson_checker.sv
// Johnson counter monitor: decodes samples, locks onto a count direction, counts violations.
module johnson_checker
    import johnson_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_W      = 8,
    localparam int unsigned SEQ_LEN   = 2 * WIDTH,
    localparam int unsigned IDX_W     = $clog2(SEQ_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] jc_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o,
    output logic             dir_o,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

    logic             cur_legal;
    logic [IDX_W-1:0] cur_idx;

    logic [IDX_W-1:0] index_q, index_d;
    logic             valid_q, valid_d;
    logic             state_q, state_d;
    logic             dir_q, dir_d;
    logic             cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [IDX_W-1:0] idx_fwd, idx_bwd;
    step_e            step;
    logic             step_valid;
    logic             step_dir;
    logic             violation;

    johnson_checker_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .jc_i    (jc_i),
        .legal_o (cur_legal),
        .index_o (cur_idx)
    );

    always_comb begin
        idx_fwd = (index_q == IDX_W'(SEQ_LEN - 1)) ? '0 : index_q + 1'b1;
        idx_bwd = (index_q == '0) ? IDX_W'(SEQ_LEN - 1) : index_q - 1'b1;
        if (cur_idx == index_q) begin
            step = StepHold;
        end else if (cur_idx == idx_fwd) begin
            step = StepFwd;
        end else if (cur_idx == idx_bwd) begin
            step = StepBwd;
        end else begin
            step = StepJump;
        end
    end

    // index_q is only meaningful as the previous sample when that sample was legal.
    assign step_valid = cur_legal && valid_q;
    assign step_dir   = (step == StepFwd);
    assign violation  = !cur_legal || (step == StepJump) ||
                        (step == StepFwd && !dir_q) || (step == StepBwd && dir_q);

    always_comb begin
        index_d     = cur_legal ? cur_idx : index_q;
        valid_d     = cur_legal;
        state_d     = state_q;
        dir_d       = dir_q;
        cand_d      = cand_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (clear_i) begin
            state_d     = STATE_SEARCH;
            run_d       = '0;
            err_count_d = '0;
        end else if (state_q == STATE_SEARCH) begin
            if (!step_valid) begin
                run_d = '0;
            end else begin
                case (step)
                    StepHold: run_d = run_q;
                    StepJump: run_d = '0;
                    default: begin
                        if (run_q != '0 && step_dir == cand_q) begin
                            run_d = run_q + 1'b1;
                        end else begin
                            run_d  = RUN_W'(1);
                            cand_d = step_dir;
                        end
                        if (run_d == RUN_W'(LOCK_COUNT)) begin
                            state_d = STATE_LOCKED;
                            dir_d   = step_dir;
                            run_d   = '0;
                        end
                    end
                endcase
            end
        end else if (violation) begin
            err_pulse_d = 1'b1;
            state_d     = STATE_SEARCH;
            run_d       = '0;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q     <= '0;
            valid_q     <= 1'b0;
            state_q     <= STATE_SEARCH;
            dir_q       <= 1'b0;
            cand_q      <= 1'b0;
            run_q       <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            index_q     <= index_d;
            valid_q     <= valid_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            cand_q      <= cand_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign index_o     = index_q;
    assign valid_o     = valid_q;
    assign dir_o       = dir_q;
    assign locked_o    = (state_q == STATE_LOCKED);
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_johnson_checker.sv
// Self-checking bench for johnson_checker: directed scenarios plus a randomized run against a model.
module tb_johnson_checker;

    localparam int W    = 4;
    localparam int N    = 2 * W;
    localparam int LOCK = 3;

    logic       clk;
    logic       rst_ni;
    logic [3:0] jc;
    logic       clear;

    logic [2:0] index_o, index_s;
    logic       valid_o, valid_s, dir_o, dir_s, locked_o, locked_s, pulse_o, pulse_s;
    logic [7:0] count_o;
    logic [1:0] count_s;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_idx, m_valid, m_dir, m_locked, m_run, m_cand, m_pulse, m_errs;

    johnson_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .jc_i(jc), .clear_i(clear),
        .index_o(index_o), .valid_o(valid_o), .dir_o(dir_o), .locked_o(locked_o),
        .err_pulse_o(pulse_o), .err_count_o(count_o)
    );

    johnson_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .jc_i(jc), .clear_i(clear),
        .index_o(index_s), .valid_o(valid_s), .dir_o(dir_s), .locked_o(locked_s),
        .err_pulse_o(pulse_s), .err_count_o(count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code at position k of the forward sequence: k low ones, then ones shrinking from the top.
    function automatic logic [3:0] ref_code(input int k);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < W; b++) begin
            if (k <= W) c[b] = (b < k);
            else        c[b] = (b >= k - W);
        end
        return c;
    endfunction

    function automatic int ref_decode(input logic [3:0] c);
        for (int k = 0; k < N; k++) begin
            if (ref_code(k) == c) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_valid = 0; m_dir = 0; m_locked = 0;
        m_run = 0; m_cand = 0; m_pulse = 0; m_errs = 0;
    endtask

    task automatic model_update(input logic [3:0] c, input logic clr);
        int cur, d, dirn, ok;
        cur = ref_decode(c);
        d = (cur >= 0 && m_valid != 0) ? (cur - m_idx + N) % N : -1;
        m_pulse = 0;
        if (clr) begin
            m_locked = 0; m_run = 0; m_errs = 0;
        end else if (m_locked == 0) begin
            if (d < 0) begin
                m_run = 0;
            end else if (d == 1 || d == N - 1) begin
                dirn = (d == 1);
                if (m_run > 0 && dirn == m_cand) m_run++;
                else begin m_run = 1; m_cand = dirn; end
                if (m_run == LOCK) begin m_locked = 1; m_dir = dirn; m_run = 0; end
            end else if (d != 0) begin
                m_run = 0;
            end
        end else begin
            ok = (cur >= 0) && (d == 0 || (m_dir == 1 && d == 1) || (m_dir == 0 && d == N - 1));
            if (!ok) begin m_pulse = 1; m_errs++; m_locked = 0; m_run = 0; end
        end
        m_valid = (cur >= 0);
        if (cur >= 0) m_idx = cur;
    endtask

    task automatic tick(input logic [3:0] c, input logic clr);
        jc = c;
        clear = clr;
        @(posedge clk);
        model_update(c, clr);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        tick(4'b0001, 1'b0);
        tick(4'b0011, 1'b0);
        jc = 4'b0111;
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({index_o, valid_o, dir_o, locked_o, pulse_o, count_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {index_o, valid_o, dir_o, locked_o, pulse_o, count_o});
        end
        checks++;
        if ({index_s, valid_s, locked_s, count_s} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs_sat got %b want 0", {index_s, valid_s, locked_s, count_s});
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tick(4'b0111, 1'b0);
        checks++;
        if (index_o !== 3'd3 || valid_o !== 1'b1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got idx=%0d v=%0d l=%0d want idx=3 v=1 l=0",
                     index_o, valid_o, locked_o);
        end
    endtask

    task automatic test_forward_lock();
        logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(seq[i], 1'b0);
            checks++;
            if (locked_o !== (i == 3)) begin
                errors++;
                $display("FAIL fwd_lock step%0d got locked=%0d want %0d", i, locked_o, i == 3);
            end
        end
        checks++;
        if (dir_o !== 1'b1) begin
            errors++;
            $display("FAIL fwd_dir got %0d want 1", dir_o);
        end
        for (int k = 4; k <= N; k++) begin
            tick(ref_code(k % N), 1'b0);
            checks++;
            if (index_o !== 3'(k % N) || locked_o !== 1'b1 || pulse_o !== 1'b0) begin
                errors++;
                $display("FAIL fwd_wrap k=%0d got idx=%0d l=%0d p=%0d want idx=%0d l=1 p=0",
                         k, index_o, locked_o, pulse_o, k % N);
            end
        end
    endtask

    task automatic test_backward_hold();
        logic [3:0] seq [5] = '{4'b0000, 4'b1000, 4'b1000, 4'b1100, 4'b1110};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(seq[i], 1'b0);
            checks++;
            if (locked_o !== (i == 4)) begin
                errors++;
                $display("FAIL bwd_lock step%0d got locked=%0d want %0d", i, locked_o, i == 4);
            end
        end
        checks++;
        if (dir_o !== 1'b0 || index_o !== 3'd5) begin
            errors++;
            $display("FAIL bwd_state got dir=%0d idx=%0d want dir=0 idx=5", dir_o, index_o);
        end
    endtask

    task automatic test_violation();
        do_reset();
        tick(4'b0000, 1'b0); tick(4'b0001, 1'b0); tick(4'b0011, 1'b0); tick(4'b0111, 1'b0);
        tick(4'b1100, 1'b0);
        checks++;
        if (pulse_o !== 1'b1 || count_o !== 8'd1 || locked_o !== 1'b0 || index_o !== 3'd6) begin
            errors++;
            $display("FAIL viol_jump got p=%0d c=%0d l=%0d idx=%0d want p=1 c=1 l=0 idx=6",
                     pulse_o, count_o, locked_o, index_o);
        end
        tick(4'b0101, 1'b0);
        checks++;
        if (valid_o !== 1'b0 || index_o !== 3'd6 || count_o !== 8'd1 || pulse_o !== 1'b0) begin
            errors++;
            $display("FAIL viol_illegal got v=%0d idx=%0d c=%0d p=%0d want v=0 idx=6 c=1 p=0",
                     valid_o, index_o, count_o, pulse_o);
        end
    endtask

    task automatic test_reversal();
        logic [3:0] seq [5] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(seq[i], 1'b0);
            checks++;
            if (locked_o !== (i == 4)) begin
                errors++;
                $display("FAIL rev_lock step%0d got locked=%0d want %0d", i, locked_o, i == 4);
            end
        end
        checks++;
        if (dir_o !== 1'b0) begin
            errors++;
            $display("FAIL rev_dir got %0d want 0", dir_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            tick(4'b0101, 1'b0);
            tick(4'b0000, 1'b0); tick(4'b0001, 1'b0); tick(4'b0011, 1'b0); tick(4'b0111, 1'b0);
            tick(4'b1100, v == 5);
            if (v < 5) begin
                checks++;
                if (count_s !== 2'(v > 3 ? 3 : v) || count_o !== 8'(v) || pulse_s !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_count v=%0d got c=%0d c8=%0d p=%0d want c=%0d c8=%0d p=1",
                             v, count_s, count_o, pulse_s, v > 3 ? 3 : v, v);
                end
            end
        end
        checks++;
        if (count_s !== 2'd0 || count_o !== 8'd0 || pulse_s !== 1'b0 || locked_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got c=%0d c8=%0d p=%0d l=%0d want 0 0 0 0",
                     count_s, count_o, pulse_s, locked_s);
        end
    endtask

    task automatic test_random();
        int walk, wdir, r;
        logic [3:0] c;
        logic clr;
        do_reset();
        walk = 0;
        wdir = 1;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) wdir = 1 - wdir;
            if (r < 75) begin
                walk = (walk + (wdir != 0 ? 1 : N - 1)) % N;
                c = ref_code(walk);
            end else if (r < 88) begin
                c = ref_code(walk);
            end else begin
                c = 4'($urandom_range(0, 15));
            end
            clr = ($urandom_range(0, 59) == 0);
            tick(c, clr);
            checks++;
            if (valid_o !== 1'(m_valid) || index_o !== 3'(m_idx) || locked_o !== 1'(m_locked) ||
                dir_o !== 1'(m_dir) || pulse_o !== 1'(m_pulse)) begin
                errors++;
                $display("FAIL rand_state n=%0d got i=%0d v=%0d l=%0d d=%0d p=%0d want %0d %0d %0d %0d %0d",
                         n, index_o, valid_o, locked_o, dir_o, pulse_o,
                         m_idx, m_valid, m_locked, m_dir, m_pulse);
            end
            checks++;
            if (count_o !== 8'(m_errs > 255 ? 255 : m_errs) ||
                count_s !== 2'(m_errs > 3 ? 3 : m_errs) || locked_s !== 1'(m_locked)) begin
                errors++;
                $display("FAIL rand_count n=%0d got c8=%0d c2=%0d l2=%0d want errs=%0d l=%0d",
                         n, count_o, count_s, locked_s, m_errs, m_locked);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        jc = 4'b0000;
        clear = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_ni = 1'b1;
        test_reset();
        test_forward_lock();
        test_backward_hold();
        test_violation();
        test_reversal();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
